// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED pattern sequencer
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int PWM_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing the pattern-step strobe
module led_tick_gen #(
  parameter int BASE_DIV_LOG2 = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       clear,
  output logic       step
);

  localparam int CW = BASE_DIV_LOG2 + 3;

  logic [CW-1:0] count;
  logic [CW-1:0] terminal;

  // At SPEED=3 the shift overflows to zero and the subtraction wraps to all-ones, the correct terminal.
  always_comb terminal = (CW'(1) << (BASE_DIV_LOG2 + int'(speed))) - CW'(1);

  // >= lets a speed reduction below the current count fire on the next cycle.
  assign step = !clear && !pause && (count >= terminal);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!pause) begin
      if (count >= terminal) count <= '0;
      else                   count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern generator (blink/chase/bounce/count); LED_PWM_EN adds BRIGHT dimming
module led_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int BASE_DIV_LOG2 = 20
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [1:0]          MODE,
  input  logic [1:0]          SPEED,
  input  logic                PAUSE,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]    BRIGHT,
`endif
  output logic [NUM_LEDS-1:0] LEDG,
  output logic                TICK
);

  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);
  // Bounce turnaround targets; both collapse to bit0 when there is a single LED.
  localparam int TURN_DOWN = (NUM_LEDS > 1) ? NUM_LEDS - 2 : 0;
  localparam int TURN_UP   = (NUM_LEDS > 1) ? 1 : 0;

  mode_e               mode_in;
  mode_e               mode_q;
  dir_e                dir_q;
  dir_e                dir_d;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [NUM_LEDS-1:0] pattern_d;
  logic                mode_chg;
  logic                step;

  assign mode_in  = mode_e'(MODE);
  assign mode_chg = (mode_in != mode_q);

  led_tick_gen #(
    .BASE_DIV_LOG2(BASE_DIV_LOG2)
  ) u_tick_gen (
    .clk    (CLOCK_50),
    .resetn (RESET_N),
    .speed  (SPEED),
    .pause  (PAUSE),
    .clear  (mode_chg),
    .step   (step)
  );

  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    if (mode_chg) begin
      dir_d     = DIR_UP;
      pattern_d = (mode_in == MODE_CHASE || mode_in == MODE_BOUNCE) ? ONE : '0;
    end else if (step) begin
      case (mode_q)
        MODE_BLINK: pattern_d = ~pattern_q;
        MODE_CHASE: pattern_d = (pattern_q << 1) | (pattern_q >> (NUM_LEDS - 1));
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pattern_q[NUM_LEDS-1]) begin
              dir_d     = DIR_DOWN;
              pattern_d = ONE << TURN_DOWN;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_d     = DIR_UP;
              pattern_d = ONE << TURN_UP;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        default: pattern_d = pattern_q + ONE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      mode_q    <= MODE_BLINK;
      pattern_q <= '0;
      dir_q     <= DIR_UP;
      TICK      <= 1'b0;
    end else begin
      mode_q    <= mode_in;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      TICK      <= step;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  // Gate the next pattern so a new step still appears on LEDG in the same cycle as TICK.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      pwm_cnt <= '0;
      LEDG    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      LEDG    <= pattern_d & {NUM_LEDS{pwm_cnt < BRIGHT}};
    end
  end
`else
  assign LEDG = pattern_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer (NUM_LEDS=8, BASE_DIV_LOG2=2)
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       pause;
  logic [3:0] bright;
  logic [7:0] ledg;
  logic       tick;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  led_sequencer #(
    .NUM_LEDS      (8),
    .BASE_DIV_LOG2 (2)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (resetn),
    .MODE     (mode),
    .SPEED    (speed),
    .PAUSE    (pause),
`ifdef LED_PWM_EN
    .BRIGHT   (bright),
`endif
    .LEDG     (ledg),
    .TICK     (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (tick !== 1'b1 && cyc < budget);
    if (tick !== 1'b1) begin
      check_eq("tick_timeout", {31'b0, tick}, 32'd1);
      cyc = -1;
    end
  endtask

  // Pop one expected LEDG value per TICK and check the spacing between ticks.
  task automatic run_steps(input string tag, input int period);
    int         cyc;
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_tick(period + 4, cyc);
      if (cyc < 0) begin
        exp_q.delete();
        return;
      end
      check_eq({tag, "_period"}, cyc, period);
      check_eq(tag, {24'b0, ledg}, {24'b0, e});
    end
  endtask

  task automatic check_reset_cycles();
    repeat (3) begin
      cycle();
      check_eq("rst_ledg", {24'b0, ledg}, 32'h0);
      check_eq("rst_tick", {31'b0, tick}, 32'h0);
    end
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    mode   = 2'd0;
    speed  = 2'd0;
    pause  = 1'b0;
    bright = 4'hf;
    check_reset_cycles();

    resetn = 1'b1;
    exp_q.push_back(8'hff);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hff);
    run_steps("blink", 4);

    mode = 2'd1;
    cycle();
    check_eq("chase_seed", {24'b0, ledg}, 32'h01);
    check_eq("chase_seed_tick", {31'b0, tick}, 32'h0);
    for (int i = 1; i <= 10; i++) exp_q.push_back(8'(1 << (i % 8)));
    run_steps("chase", 4);

    // Held count is 1 when PAUSE rises.
    cycle();
    pause = 1'b1;
    seen  = 0;
    repeat (20) begin
      cycle();
      seen += int'(tick);
    end
    check_eq("pause_tick", seen, 0);
    check_eq("pause_ledg", {24'b0, ledg}, 32'h04);
    pause = 1'b0;
    exp_q.push_back(8'h08);
    run_steps("pause_resume", 3);

    // Prescaler is at terminal here: the mode change must win over the step.
    repeat (3) cycle();
    mode = 2'd3;
    cycle();
    check_eq("modechg_ledg", {24'b0, ledg}, 32'h00);
    check_eq("modechg_tick", {31'b0, tick}, 32'h0);
    exp_q.push_back(8'h01);
    run_steps("modechg_clear", 4);

    speed = 2'd2;
    for (int i = 2; i <= 256; i++) exp_q.push_back(8'(i));
    run_steps("count", 16);

    speed = 2'd3;
    repeat (20) cycle();
    speed = 2'd0;
    exp_q.push_back(8'h01);
    run_steps("speed_drop", 1);

    mode = 2'd2;
    cycle();
    check_eq("bounce_seed", {24'b0, ledg}, 32'h01);
    for (int i = 1; i <= 7; i++) exp_q.push_back(8'(1 << i));
    for (int i = 6; i >= 0; i--) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    run_steps("bounce", 4);

    mode = 2'd1;
    cycle();
    check_eq("chase2_seed", {24'b0, ledg}, 32'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    run_steps("chase2", 4);
    cycle();
    resetn = 1'b0;
    check_reset_cycles();
    resetn = 1'b1;
    mode   = 2'd0;
    exp_q.push_back(8'hff);
    exp_q.push_back(8'h00);
    run_steps("blink_after_rst", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
